// File: rtl/music_box_pkg.sv
// Shared types, note tables and FSM states for the music box sequencer.
// Each table entry is {freq, dur}; dur==0 marks the end of a song.
package music_box_pkg;

    localparam int TABLE_DEPTH = 32;

    typedef struct packed {
        logic [9:0] freq;
        logic [7:0] dur;
    } note_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP,
        DONE
    } seq_state_t;

    localparam note_entry_t SONG0_TABLE [TABLE_DEPTH] = '{
        '{10'd262, 8'd25}, '{10'd294, 8'd25}, '{10'd330, 8'd50}, '{10'd0,   8'd10},
        '{10'd262, 8'd50}, '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},
        '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},
        '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},
        '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},
        '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},
        '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},
        '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0},  '{10'd0,   8'd0}
    };

    // Full-length song: no terminator, so playback ends after the last index.
    localparam note_entry_t SONG1_TABLE [TABLE_DEPTH] = '{
        '{10'd262, 8'd3}, '{10'd294, 8'd2}, '{10'd330, 8'd3}, '{10'd349, 8'd2},
        '{10'd392, 8'd3}, '{10'd440, 8'd2}, '{10'd494, 8'd3}, '{10'd523, 8'd2},
        '{10'd523, 8'd3}, '{10'd494, 8'd2}, '{10'd440, 8'd3}, '{10'd392, 8'd2},
        '{10'd349, 8'd3}, '{10'd330, 8'd2}, '{10'd294, 8'd3}, '{10'd262, 8'd2},
        '{10'd0,   8'd4}, '{10'd392, 8'd2}, '{10'd392, 8'd2}, '{10'd440, 8'd3},
        '{10'd392, 8'd2}, '{10'd330, 8'd3}, '{10'd294, 8'd2}, '{10'd262, 8'd3},
        '{10'd330, 8'd2}, '{10'd330, 8'd2}, '{10'd294, 8'd2}, '{10'd294, 8'd2},
        '{10'd262, 8'd4}, '{10'd0,   8'd2}, '{10'd262, 8'd2}, '{10'd523, 8'd5}
    };

endpackage

// File: rtl/song_rom.sv
// Combinational note-table lookup by song number and note index.
// Kept apart from the sequencer so tables can change without touching it.
module song_rom
    import music_box_pkg::*;
#(
    parameter int INDEX_W = 5
) (
    input  logic               song_select,
    input  logic [INDEX_W-1:0] note_index,
    output note_entry_t        entry
);

    // Select the entry from the latched song's table
    always_comb begin
        entry = song_select ? SONG1_TABLE[note_index]
                            : SONG0_TABLE[note_index];
    end

endmodule

// File: rtl/song_sequencer.sv
// Steps through a song table one 10 ms tick at a time, driving the
// frequency word with a silent gap after each note.
module song_sequencer
    import music_box_pkg::*;
#(
    parameter int GAP_TICKS = 2,
    parameter int MAX_NOTES = 32,
    parameter int INDEX_W   = 5
) (
    input  logic               CLK_100hz,
    input  logic               systemReset_n,
    input  logic               start_song0_n,
    input  logic               start_song1_n,
    input  logic               stop,
    output logic [9:0]         note_frequency,
    output logic               note_active,
    output logic               song_playing,
    output logic               song_select,
    output logic [INDEX_W-1:0] note_index,
    output logic               song_done
);

    // A zero-gap build still needs a legal one-bit counter.
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    seq_state_t         state, state_n;
    logic [7:0]         tick_cnt, tick_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic [9:0]         freq_n;
    logic               active_n, playing_n, select_n, done_n;
    logic [INDEX_W-1:0] index_n;
    logic               prev0, prev1;
    logic               edge0, edge1, last_note;
    note_entry_t        entry;

    song_rom #(.INDEX_W(INDEX_W)) u_rom (
        .song_select (song_select),
        .note_index  (note_index),
        .entry       (entry)
    );

    assign edge0     = prev0 & ~start_song0_n;
    assign edge1     = prev1 & ~start_song1_n;
    assign last_note = (note_index == INDEX_W'(MAX_NOTES - 1));

    // State, counters, button history and registered outputs
    always_ff @(posedge CLK_100hz or negedge systemReset_n) begin
        if (!systemReset_n) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            gap_cnt        <= '0;
            note_frequency <= '0;
            note_active    <= 1'b0;
            song_playing   <= 1'b0;
            song_select    <= 1'b0;
            note_index     <= '0;
            song_done      <= 1'b0;
            prev0          <= 1'b1;
            prev1          <= 1'b1;
        end else begin
            state          <= state_n;
            tick_cnt       <= tick_n;
            gap_cnt        <= gap_n;
            note_frequency <= freq_n;
            note_active    <= active_n;
            song_playing   <= playing_n;
            song_select    <= select_n;
            note_index     <= index_n;
            song_done      <= done_n;
            prev0          <= start_song0_n;
            prev1          <= start_song1_n;
        end
    end

    // Next-state and next-output decode; stop outranks everything
    always_comb begin
        state_n   = state;
        tick_n    = tick_cnt;
        gap_n     = gap_cnt;
        freq_n    = note_frequency;
        active_n  = note_active;
        playing_n = song_playing;
        select_n  = song_select;
        index_n   = note_index;
        done_n    = 1'b0;
        if (stop && state != IDLE) begin
            state_n   = IDLE;
            tick_n    = '0;
            gap_n     = '0;
            freq_n    = '0;
            active_n  = 1'b0;
            playing_n = 1'b0;
            index_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    freq_n   = '0;
                    active_n = 1'b0;
                    if (!stop && (edge0 || edge1)) begin
                        select_n  = ~edge0;
                        index_n   = '0;
                        playing_n = 1'b1;
                        state_n   = LOAD;
                    end
                end
                LOAD: begin
                    if (entry.dur == 8'd0) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        freq_n   = entry.freq;
                        active_n = (entry.freq != 10'd0);
                        tick_n   = entry.dur;
                        state_n  = PLAY;
                    end
                end
                PLAY: begin
                    if (tick_cnt == 8'd1) begin
                        tick_n = '0;
                        if (GAP_TICKS > 0) begin
                            gap_n    = GAP_W'(GAP_TICKS);
                            freq_n   = '0;
                            active_n = 1'b0;
                            state_n  = GAP;
                        end else if (last_note) begin
                            freq_n   = '0;
                            active_n = 1'b0;
                            done_n   = 1'b1;
                            state_n  = DONE;
                        end else begin
                            index_n = note_index + 1'b1;
                            state_n = LOAD;
                        end
                    end else begin
                        tick_n = tick_cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_n = '0;
                        if (last_note) begin
                            done_n  = 1'b1;
                            state_n = DONE;
                        end else begin
                            index_n = note_index + 1'b1;
                            state_n = LOAD;
                        end
                    end else begin
                        gap_n = gap_cnt - GAP_W'(1);
                    end
                end
                DONE: begin
                    index_n   = '0;
                    playing_n = 1'b0;
                    state_n   = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench: builds a per-cycle expected trace for each song from
// the note tables and compares it cycle by cycle against the sequencer.
module tb_song_sequencer;
    import music_box_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s0_n = 1'b1;
    logic       s1_n = 1'b1;
    logic       stop = 1'b0;
    logic [9:0] freq;
    logic       active, playing, sel, done;
    logic [4:0] idx;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [9:0] f;
        logic       a;
        logic       p;
        logic       d;
        logic [4:0] i;
        logic       s;
    } exp_t;

    exp_t sb[$];

    song_sequencer dut (
        .CLK_100hz      (clk),
        .systemReset_n  (rst_n),
        .start_song0_n  (s0_n),
        .start_song1_n  (s1_n),
        .stop           (stop),
        .note_frequency (freq),
        .note_active    (active),
        .song_playing   (playing),
        .song_select    (sel),
        .note_index     (idx),
        .song_done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_freq"}, 32'(freq), 0);
        check({tag, "_active"}, 32'(active), 0);
        check({tag, "_playing"}, 32'(playing), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_index"}, 32'(idx), 0);
    endtask

    // Song0 as written out in the design notes; Song1 from the shared table.
    function automatic note_entry_t ref_entry(input logic s, input int k);
        note_entry_t e;
        e = '{10'd0, 8'd0};
        if (!s) begin
            case (k)
                0: e = '{10'd262, 8'd25};
                1: e = '{10'd294, 8'd25};
                2: e = '{10'd330, 8'd50};
                3: e = '{10'd0,   8'd10};
                4: e = '{10'd262, 8'd50};
                default: e = '{10'd0, 8'd0};
            endcase
        end else begin
            e = SONG1_TABLE[k];
        end
        return e;
    endfunction

    task automatic push(input logic [9:0] f, input logic a, input logic p,
                        input logic d, input int i, input logic s);
        exp_t e;
        e.f = f;
        e.a = a;
        e.p = p;
        e.d = d;
        e.i = 5'(i);
        e.s = s;
        sb.push_back(e);
    endtask

    // Expected outputs from the cycle after the start edge is sampled
    task automatic build_song(input logic s);
        note_entry_t e;
        for (int k = 0; k < 32; k++) begin
            e = ref_entry(s, k);
            push(10'd0, 1'b0, 1'b1, 1'b0, k, s);
            if (e.dur == 8'd0) begin
                push(10'd0, 1'b0, 1'b1, 1'b1, k, s);
                push(10'd0, 1'b0, 1'b0, 1'b0, 0, s);
                return;
            end
            for (int t = 0; t < int'(e.dur); t++)
                push(e.freq, e.freq != 10'd0, 1'b1, 1'b0, k, s);
            for (int g = 0; g < 2; g++)
                push(10'd0, 1'b0, 1'b1, 1'b0, k, s);
            if (k == 31) begin
                push(10'd0, 1'b0, 1'b1, 1'b1, k, s);
                push(10'd0, 1'b0, 0, 1'b0, 0, s);
                return;
            end
        end
    endtask

    // Pop and compare up to limit cycles; optionally press Song1 at poke_at
    task automatic run_trace(input string tag, input int limit,
                             input int poke_at);
        exp_t e;
        int n;
        n = 0;
        while (sb.size() > 0 && n < limit) begin
            e = sb.pop_front();
            check($sformatf("%s_c%0d_freq", tag, n), 32'(freq), 32'(e.f));
            check($sformatf("%s_c%0d_active", tag, n), 32'(active), 32'(e.a));
            check($sformatf("%s_c%0d_playing", tag, n), 32'(playing), 32'(e.p));
            check($sformatf("%s_c%0d_done", tag, n), 32'(done), 32'(e.d));
            check($sformatf("%s_c%0d_index", tag, n), 32'(idx), 32'(e.i));
            check($sformatf("%s_c%0d_select", tag, n), 32'(sel), 32'(e.s));
            if (n == poke_at)
                s1_n = 1'b0;
            n++;
            tick();
        end
    endtask

    initial begin
        // Reset state
        #2;
        check_idle("reset");
        check("reset_select", 32'(sel), 0);
        #20;
        rst_n = 1'b1;
        repeat (3) tick();
        check_idle("post_reset");

        // Song0 end to end; Song1 pressed mid-song and held
        s0_n = 1'b0;
        build_song(1'b0);
        tick();
        run_trace("song0", 10000, 60);
        check("song0_drained", 32'(sb.size()), 0);
        for (int k = 0; k < 5; k++) begin
            check_idle("held_no_restart");
            tick();
        end
        s0_n = 1'b1;
        s1_n = 1'b1;
        repeat (2) tick();

        // Song1 runs to its last index without a terminator
        s1_n = 1'b0;
        build_song(1'b1);
        tick();
        s1_n = 1'b1;
        run_trace("song1", 10000, -1);
        check("song1_drained", 32'(sb.size()), 0);
        check("song1_select_kept", 32'(sel), 1);
        repeat (2) tick();
        check_idle("song1_after");

        // Stop during the second note, then replay from index 0
        s0_n = 1'b0;
        build_song(1'b0);
        tick();
        run_trace("pre_stop", 40, -1);
        sb.delete();
        check("pre_stop_index", 32'(idx), 1);
        check("pre_stop_freq", 32'(freq), 294);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_idle("after_stop");
            tick();
        end
        s0_n = 1'b1;
        tick();
        s0_n = 1'b0;
        build_song(1'b0);
        tick();
        run_trace("replay", 10000, -1);
        s0_n = 1'b1;
        repeat (2) tick();

        // Both buttons fall together: Song0 wins
        s0_n = 1'b0;
        s1_n = 1'b0;
        build_song(1'b0);
        tick();
        run_trace("both", 10000, -1);
        s0_n = 1'b1;
        s1_n = 1'b1;
        repeat (2) tick();

        // Asynchronous reset in the middle of a Song1 note
        s1_n = 1'b0;
        build_song(1'b1);
        tick();
        run_trace("pre_rst", 3, -1);
        sb.delete();
        check("pre_rst_freq", 32'(freq), 262);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_select", 32'(sel), 0);
        s1_n = 1'b1;
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_idle("rst_no_resume");
        end
        s0_n = 1'b0;
        build_song(1'b0);
        tick();
        run_trace("resume", 30, -1);
        sb.delete();
        s0_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
